// File: rtl/palette_mixer_pkg.sv
// ---------------------------------------------------------------------------
// palette_mixer_pkg
//   Shared definitions for the palette mixer slice.
//   - flash_state_e   : hit-flash FSM states (IDLE / ON / OFF)
//   - IDX_TRANSPARENT : palette index that marks a layer pixel as empty
//   - cnt_width()     : counter width helper, never returns less than 1 bit
// ---------------------------------------------------------------------------
package palette_mixer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } flash_state_e;

   localparam logic [2:0] IDX_TRANSPARENT = 3'd0;

   // $clog2 of 1 is 0, which would give a zero-width counter; clamp to 1.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// ---------------------------------------------------------------------------
// layer_priority_sel
//   Combinational priority picker across the sprite layers. Layer 0 has the
//   highest priority; the first layer with a non-transparent index wins.
//   Ports:
//     layer_idx : NUM_LAYERS x 3-bit palette indices, layer i at [i*3 +: 3]
//     index     : winning palette index (IDX_TRANSPARENT when nothing hits)
//     layer     : winning layer number (0 when nothing hits)
//     hit       : 1 when at least one layer is non-transparent
// ---------------------------------------------------------------------------
module layer_priority_sel
   import palette_mixer_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int LAYER_W    = cnt_width(NUM_LAYERS)
) (
   input  logic [NUM_LAYERS*3-1:0] layer_idx,
   output logic [2:0]              index,
   output logic [LAYER_W-1:0]      layer,
   output logic                    hit
);

   // Walk from the lowest priority upwards so the last assignment made is
   // from the lowest-numbered non-transparent layer.
   always_comb begin
      index = IDX_TRANSPARENT;
      layer = '0;
      hit   = 1'b0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_idx[i*3 +: 3] != IDX_TRANSPARENT) begin
            index = layer_idx[i*3 +: 3];
            layer = LAYER_W'(i);
            hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/palette_mixer_ctrl.sv
// ---------------------------------------------------------------------------
// palette_mixer_ctrl
//   Two-stage pixel mixer with a hit-flash effect on one sprite layer.
//   Stage 1 registers the winning layer/index, whose index addresses an
//   external combinational palette; stage 2 registers the final colour.
//   A frame-rate FSM blinks the flash layer to white for FLASH_BLINKS
//   ON phases of FLASH_FRAMES frames each.
//
//   Pipeline flow control: pixel_en is a qualifying strobe with no back
//   pressure. A pixel is accepted, and every pipeline register advances,
//   on exactly those Clk edges where pixel_en=1; with pixel_en=0 the whole
//   pipeline holds. The flash FSM runs on every Clk edge regardless.
//
//   Ports:
//     Clk, Reset_n            : clock, asynchronous active-low reset
//     pixel_en                : pipeline advance strobe
//     blank                   : 1 = active display, 0 = blanking
//     frame_start             : one-Clk pulse per frame
//     layer_idx               : NUM_LAYERS x 3-bit per-layer palette index
//     flash_req               : one-Clk pulse that (re)starts the flash
//     pal_select              : index to the external palette
//     pal_red/green/blue      : palette response to pal_select
//     Red/Green/Blue          : registered output pixel colour
//     flash_busy              : flash FSM not in IDLE
//     dbg_state/fcnt/bcnt     : flash FSM state and counters for observation
// ---------------------------------------------------------------------------
module palette_mixer_ctrl
   import palette_mixer_pkg::*;
#(
   parameter int         NUM_LAYERS   = 4,
   parameter int         FLASH_LAYER  = 1,
   parameter int         FLASH_FRAMES = 4,
   parameter int         FLASH_BLINKS = 3,
   parameter logic [7:0] BG_R         = 8'h00,
   parameter logic [7:0] BG_G         = 8'h00,
   parameter logic [7:0] BG_B         = 8'h40,
   localparam int        LAYER_W      = cnt_width(NUM_LAYERS),
   localparam int        FCNT_W       = cnt_width(FLASH_FRAMES),
   localparam int        BCNT_W       = cnt_width(FLASH_BLINKS + 1)
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    pixel_en,
   input  logic                    blank,
   input  logic                    frame_start,
   input  logic [NUM_LAYERS*3-1:0] layer_idx,
   input  logic                    flash_req,
   output logic [2:0]              pal_select,
   input  logic [7:0]              pal_red,
   input  logic [7:0]              pal_green,
   input  logic [7:0]              pal_blue,
   output logic [7:0]              Red,
   output logic [7:0]              Green,
   output logic [7:0]              Blue,
   output logic                    flash_busy,
   output flash_state_e            dbg_state,
   output logic [FCNT_W-1:0]       dbg_fcnt,
   output logic [BCNT_W-1:0]       dbg_bcnt
);

   // ------------------------------------------------------------------
   // Flash FSM
   // ------------------------------------------------------------------
   flash_state_e      state, state_d;
   logic [FCNT_W-1:0] fcnt, fcnt_d;
   logic [BCNT_W-1:0] bcnt, bcnt_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         fcnt  <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_d;
         fcnt  <= fcnt_d;
         bcnt  <= bcnt_d;
      end
   end

   // flash_req is checked before frame_start so a coincident frame_start
   // is swallowed by the restart instead of advancing fcnt.
   always_comb begin
      state_d = state;
      fcnt_d  = fcnt;
      bcnt_d  = bcnt;
      case (state)
         IDLE: begin
            if (flash_req) begin
               state_d = ON;
               fcnt_d  = '0;
               bcnt_d  = '0;
            end
         end
         ON, OFF: begin
            if (flash_req) begin
               state_d = ON;
               fcnt_d  = '0;
               bcnt_d  = '0;
            end else if (frame_start) begin
               if (fcnt == FCNT_W'(FLASH_FRAMES - 1)) begin
                  fcnt_d = '0;
                  if (state == ON) begin
                     state_d = OFF;
                     bcnt_d  = bcnt + BCNT_W'(1);
                  end else if (bcnt == BCNT_W'(FLASH_BLINKS)) begin
                     state_d = IDLE;
                     bcnt_d  = '0;
                  end else begin
                     state_d = ON;
                  end
               end else begin
                  fcnt_d = fcnt + FCNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            fcnt_d  = '0;
            bcnt_d  = '0;
         end
      endcase
   end

   assign flash_busy = (state != IDLE);
   assign dbg_state  = state;
   assign dbg_fcnt   = fcnt;
   assign dbg_bcnt   = bcnt;

   // ------------------------------------------------------------------
   // Stage 1: layer priority
   // ------------------------------------------------------------------
   logic [2:0]         sel_index;
   logic [LAYER_W-1:0] sel_layer;
   logic               sel_hit;

   layer_priority_sel #(
      .NUM_LAYERS (NUM_LAYERS),
      .LAYER_W    (LAYER_W)
   ) u_sel (
      .layer_idx (layer_idx),
      .index     (sel_index),
      .layer     (sel_layer),
      .hit       (sel_hit)
   );

   logic [2:0]         win_idx_q;
   logic [LAYER_W-1:0] win_layer_q;
   logic               hit_q;
   logic               blank_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         win_idx_q   <= '0;
         win_layer_q <= '0;
         hit_q       <= 1'b0;
         blank_q     <= 1'b0;
      end else if (pixel_en) begin
         win_idx_q   <= sel_index;
         win_layer_q <= sel_layer;
         hit_q       <= sel_hit;
         blank_q     <= blank;
      end
   end

   assign pal_select = win_idx_q;

   // ------------------------------------------------------------------
   // Stage 2: colour select
   // ------------------------------------------------------------------
   logic [23:0] rgb_d;

   // The flash override keys on the winning layer only, so it applies even
   // when that layer is the default 0 of an all-transparent pixel.
   always_comb begin
      rgb_d = {BG_R, BG_G, BG_B};
      if (!blank_q) begin
         rgb_d = 24'h000000;
      end else if (state == ON && win_layer_q == LAYER_W'(FLASH_LAYER)) begin
         rgb_d = 24'hFFFFFF;
      end else if (hit_q) begin
         rgb_d = {pal_red, pal_green, pal_blue};
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Red   <= '0;
         Green <= '0;
         Blue  <= '0;
      end else if (pixel_en) begin
         {Red, Green, Blue} <= rgb_d;
      end
   end

endmodule

// File: tb/tb_palette_mixer_ctrl.sv
module tb_palette_mixer_ctrl;
   import palette_mixer_pkg::*;

   localparam int FL = 1;

   // ---------------- clock / reset ----------------
   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        pixel_en = 1'b0;
   logic        blank = 1'b0;
   logic        frame_start = 1'b0;
   logic        flash_req = 1'b0;
   logic [11:0] layer_idx = '0;
   logic [2:0]  pal_select;
   logic [7:0]  pal_red, pal_green, pal_blue;
   logic [7:0]  Red, Green, Blue;
   logic        flash_busy;
   flash_state_e dbg_state;
   logic [1:0]  dbg_fcnt, dbg_bcnt;

   always #5 Clk = ~Clk;

   palette_mixer_ctrl dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .pixel_en    (pixel_en),
      .blank       (blank),
      .frame_start (frame_start),
      .layer_idx   (layer_idx),
      .flash_req   (flash_req),
      .pal_select  (pal_select),
      .pal_red     (pal_red),
      .pal_green   (pal_green),
      .pal_blue    (pal_blue),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .flash_busy  (flash_busy),
      .dbg_state   (dbg_state),
      .dbg_fcnt    (dbg_fcnt),
      .dbg_bcnt    (dbg_bcnt)
   );

   // external palette: index 3 is 80/00/00, the rest are distinct colours
   function automatic logic [23:0] pal_model(input logic [2:0] i);
      if (i == 3'd3) return 24'h800000;
      return {i, 5'h11, 8'h20 + {5'd0, i}, 8'hC0 - {5'd0, i}};
   endfunction

   always_comb {pal_red, pal_green, pal_blue} = pal_model(pal_select);

   // ---------------- scoreboard state ----------------
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [6:0]  exp_q[$];        // {blank, hit, layer[1:0], idx[2:0]}
   logic [23:0] last_rgb = '0;
   logic [2:0]  last_idx = '0;
   bit          flash_active = 1'b0;
   int          flash_pos = 0;   // frame_starts since the flash began

   function automatic flash_state_e model_state();
      if (!flash_active) return IDLE;
      return ((flash_pos / 4) % 2 == 0) ? ON : OFF;
   endfunction

   function automatic logic [1:0] model_fcnt();
      return flash_active ? 2'(flash_pos % 4) : 2'd0;
   endfunction

   function automatic logic [1:0] model_bcnt();
      return flash_active ? 2'((flash_pos + 4) / 8) : 2'd0;
   endfunction

   function automatic logic [6:0] stage1_model(input logic [11:0] layers, input logic blk);
      logic [2:0] v;
      for (int i = 0; i < 4; i++) begin
         v = layers[i*3 +: 3];
         if (v != 3'd0) return {blk, 1'b1, 2'(i), v};
      end
      return {blk, 1'b0, 2'd0, 3'd0};
   endfunction

   function automatic logic [23:0] colour_model(input logic [6:0] e);
      if (!e[6]) return 24'h000000;
      if (model_state() == ON && e[4:3] == 2'(FL)) return 24'hFFFFFF;
      if (e[5]) return pal_model(e[2:0]);
      return 24'h000040;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // one accepted pixel; pops and checks the pixel accepted one strobe ago
   task automatic strobe(input logic [11:0] layers, input logic blk, input string tag);
      logic [6:0]  e;
      logic [23:0] exp_rgb;
      layer_idx = layers;
      blank     = blk;
      pixel_en  = 1'b1;
      e = stage1_model(layers, blk);
      exp_q.push_back(e);
      exp_rgb = colour_model(exp_q[0]);
      tick();
      pixel_en = 1'b0;
      total_cnt++;
      if (pal_select !== e[2:0])
         $display("FAIL %s pal_select: got %0d expected %0d", tag, pal_select, e[2:0]);
      else pass_cnt++;
      last_idx = e[2:0];
      if (exp_q.size() >= 2) begin
         void'(exp_q.pop_front());
         total_cnt++;
         if ({Red, Green, Blue} !== exp_rgb)
            $display("FAIL %s rgb: got %h expected %h", tag, {Red, Green, Blue}, exp_rgb);
         else pass_cnt++;
         last_rgb = exp_rgb;
      end
   endtask

   task automatic pulse(input logic req, input logic fs);
      flash_req   = req;
      frame_start = fs;
      tick();
      flash_req   = 1'b0;
      frame_start = 1'b0;
      if (req) begin
         flash_active = 1'b1;
         flash_pos    = 0;
      end else if (fs && flash_active) begin
         flash_pos++;
         if (flash_pos == 24) flash_active = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 Reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({Red, Green, Blue} !== 24'h0) $display("FAIL reset rgb: got %h expected 000000", {Red, Green, Blue});
      else pass_cnt++;
      total_cnt++;
      if (pal_select !== 3'd0) $display("FAIL reset pal_select: got %0d expected 0", pal_select);
      else pass_cnt++;
      total_cnt++;
      if (flash_busy !== 1'b0 || dbg_state !== IDLE)
         $display("FAIL reset fsm: got busy=%b state=%0d expected busy=0 state=0", flash_busy, dbg_state);
      else pass_cnt++;
      tick();
      tick();
      Reset_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(7'd0);
      tick();
   endtask

   task automatic test_priority();
      strobe(12'b010_101_011_000, 1'b1, "prio_0352");
      strobe(12'b010_101_011_000, 1'b1, "prio_0352_b");
      strobe(12'b000_000_000_110, 1'b1, "prio_l0");
      strobe(12'b111_000_000_000, 1'b1, "prio_l3");
      strobe(12'b001_010_000_000, 1'b1, "prio_l2");
      for (int i = 0; i < 8; i++)
         strobe(12'($urandom_range(0, 4095)), 1'b1, "prio_rand");
   endtask

   task automatic test_background();
      strobe(12'h000, 1'b1, "bg");
      strobe(12'h000, 1'b1, "bg_b");
   endtask

   task automatic test_blanking();
      strobe(12'b000_000_000_100, 1'b0, "blank");
      strobe(12'b000_000_000_100, 1'b0, "blank_b");
      for (int i = 0; i < 5; i++) begin
         layer_idx = 12'($urandom_range(1, 4095));
         blank     = 1'($urandom_range(0, 1));
         tick();
         total_cnt++;
         if ({Red, Green, Blue} !== last_rgb || pal_select !== last_idx)
            $display("FAIL hold: got rgb=%h sel=%0d expected rgb=%h sel=%0d",
                     {Red, Green, Blue}, pal_select, last_rgb, last_idx);
         else pass_cnt++;
      end
   endtask

   task automatic test_flash();
      pulse(1'b1, 1'b0);
      total_cnt++;
      if (dbg_state !== ON || flash_busy !== 1'b1)
         $display("FAIL flash_start: got state=%0d busy=%b expected state=1 busy=1", dbg_state, flash_busy);
      else pass_cnt++;
      for (int f = 1; f <= 24; f++) begin
         strobe(12'b000_000_101_000, 1'b1, "flash_l1");
         strobe(12'b000_000_000_010, 1'b1, "flash_l0");
         strobe(12'b000_011_000_000, 1'b1, "flash_l2");
         pulse(1'b0, 1'b1);
         total_cnt++;
         if (dbg_state !== model_state() || flash_busy !== flash_active ||
             dbg_fcnt !== model_fcnt() || dbg_bcnt !== model_bcnt())
            $display("FAIL flash_frame%0d: got st=%0d busy=%b f=%0d b=%0d expected st=%0d busy=%b f=%0d b=%0d",
                     f, dbg_state, flash_busy, dbg_fcnt, dbg_bcnt,
                     model_state(), flash_active, model_fcnt(), model_bcnt());
         else pass_cnt++;
      end
      total_cnt++;
      if (flash_busy !== 1'b0) $display("FAIL flash_end: got busy=%b expected 0", flash_busy);
      else pass_cnt++;
      strobe(12'b000_000_101_000, 1'b1, "flash_after");
      strobe(12'b000_000_101_000, 1'b1, "flash_after_b");
   endtask

   task automatic test_restart();
      pulse(1'b1, 1'b0);
      for (int f = 0; f < 6; f++) pulse(1'b0, 1'b1);
      strobe(12'b000_000_101_000, 1'b1, "restart_pre");
      pulse(1'b1, 1'b1);
      total_cnt++;
      if (dbg_state !== ON || dbg_fcnt !== 2'd0 || dbg_bcnt !== 2'd0)
         $display("FAIL restart: got st=%0d f=%0d b=%0d expected st=1 f=0 b=0", dbg_state, dbg_fcnt, dbg_bcnt);
      else pass_cnt++;
      strobe(12'b000_000_101_000, 1'b1, "restart_on");
      for (int f = 1; f <= 24; f++) begin
         pulse(1'b0, 1'b1);
         total_cnt++;
         if (dbg_state !== model_state() || flash_busy !== flash_active ||
             dbg_fcnt !== model_fcnt() || dbg_bcnt !== model_bcnt())
            $display("FAIL restart_frame%0d: got st=%0d busy=%b f=%0d b=%0d expected st=%0d busy=%b f=%0d b=%0d",
                     f, dbg_state, flash_busy, dbg_fcnt, dbg_bcnt,
                     model_state(), flash_active, model_fcnt(), model_bcnt());
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++)
         strobe(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), "b2b");
   endtask

   task automatic test_reset_mid_flash();
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      strobe(12'b000_000_101_000, 1'b1, "rst_pre");
      strobe(12'b000_000_101_000, 1'b1, "rst_pre_b");
      #2 Reset_n = 1'b0;
      #1;
      flash_active = 1'b0;
      flash_pos    = 0;
      total_cnt++;
      if ({Red, Green, Blue} !== 24'h0 || pal_select !== 3'd0 || flash_busy !== 1'b0 || dbg_state !== IDLE)
         $display("FAIL rst_mid: got rgb=%h sel=%0d busy=%b st=%0d expected rgb=000000 sel=0 busy=0 st=0",
                  {Red, Green, Blue}, pal_select, flash_busy, dbg_state);
      else pass_cnt++;
      tick();
      tick();
      Reset_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(7'd0);
      tick();
      for (int f = 0; f < 5; f++) begin
         pulse(1'b0, 1'b1);
         total_cnt++;
         if (flash_busy !== 1'b0 || dbg_state !== IDLE)
            $display("FAIL rst_after: got busy=%b st=%0d expected busy=0 st=0", flash_busy, dbg_state);
         else pass_cnt++;
      end
      strobe(12'b000_000_101_000, 1'b1, "rst_post");
      strobe(12'b000_000_101_000, 1'b1, "rst_post_b");
   endtask

   initial begin
      test_reset();
      test_priority();
      test_background();
      test_blanking();
      test_flash();
      test_restart();
      test_back_to_back();
      test_reset_mid_flash();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/palette_mixer_ctrl.md
PALETTE_MIXER_CTRL -- requirements
Module: palette_mixer_ctrl

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4: number of sprite layers; layer 0 has the highest priority.
REQ-002 SHALL have parameter FLASH_LAYER, default 1: the layer index affected by the hit flash.
REQ-003 SHALL have parameter FLASH_FRAMES, default 4: frames per flash phase (ON or OFF).
REQ-004 SHALL have parameter FLASH_BLINKS, default 3: number of ON phases per flash.
REQ-005 SHALL have parameters BG_R/BG_G/BG_B, default 8'h00/8'h00/8'h40: background colour.
REQ-006 SHALL have port Clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port pixel_en, input, 1 bit: pixel strobe; the pipeline advances only when it is 1.
REQ-009 SHALL have port blank, input, 1 bit: 1 means the display is active, 0 means blanking.
REQ-010 SHALL have port frame_start, input, 1 bit: a one-Clk pulse at the start of each frame.
REQ-011 SHALL have port layer_idx, input, NUM_LAYERS x 3 bits: per-layer palette index; 0 means transparent.
REQ-012 SHALL have port flash_req, input, 1 bit: a one-Clk pulse that starts a hit flash.
REQ-013 SHALL have port pal_select, output, 3 bits: the index sent to the external combinational palette.
REQ-014 SHALL have port pal_red/pal_green/pal_blue, input, 8 bits each: the palette's response to pal_select.
REQ-015 SHALL have port Red/Green/Blue, output, 8 bits each: the registered pixel colour.
REQ-016 SHALL have port flash_busy, output, 1 bit: 1 whenever the flash FSM is not in IDLE.

Function
REQ-017 SHALL, in stage 1, on a Clk edge with pixel_en=1, register: win_idx (index of the lowest-numbered layer whose index is non-zero, else 0), win_layer, hit (1 if any layer is non-zero), and blank.
REQ-018 SHALL drive pal_select combinationally from the registered win_idx.
REQ-019 SHALL, in stage 2, on a Clk edge with pixel_en=1, register Red/Green/Blue as follows, in priority order:
- 0 if blank_q=0;
- 8'hFF on all channels if the FSM is in ON and win_layer equals FLASH_LAYER;
- the palette response if hit=1;
- BG_R/BG_G/BG_B otherwise.
REQ-020 SHALL have a latency of exactly 2 pixel_en strobes from inputs to Red/Green/Blue.
REQ-021 SHALL hold all pipeline registers when pixel_en=0.
REQ-022 SHALL implement a flash FSM with states IDLE, ON and OFF; the frame counter fcnt has width clog2(FLASH_FRAMES) and the blink counter bcnt has width clog2(FLASH_BLINKS+1).
REQ-023 SHALL, in IDLE with flash_req=1, move to ON and set fcnt=0 and bcnt=0.
REQ-024 SHALL, in ON or OFF, increment fcnt on each frame_start; when fcnt=FLASH_FRAMES-1 it SHALL clear fcnt and toggle the phase, and on the ON-to-OFF transition it SHALL increment bcnt.
REQ-025 SHALL move from OFF to IDLE, instead of to ON, when the completing OFF phase brings bcnt to FLASH_BLINKS.
REQ-026 SHALL, on flash_req in ON or OFF, restart the flash: state ON, fcnt=0, bcnt=0.
REQ-027 SHALL, when flash_req and frame_start occur in the same cycle, apply flash_req and not count that frame_start.
REQ-028 SHALL update FSM state independently of pixel_en.

Reset
REQ-029 SHALL, while Reset_n=0, asynchronously set: FSM to IDLE, fcnt=0, bcnt=0, all pipeline registers to 0, Red/Green/Blue=0, pal_select=0 and flash_busy=0.
REQ-030 SHALL, if reset asserts mid-flash, discard the flash and not resume it after reset releases.

Structure
REQ-031 SHALL place the flash state enum and the transparent-index constant (3'd0) in the shared package palette_mixer_pkg.
REQ-032 SHALL implement the priority selection as the sub-module layer_priority_sel: combinational, NUM_LAYERS-parameterised, outputs index, layer and hit.

Verification
REQ-033 SHALL verify layer priority: layers = {0,3,5,2}, blank=1, palette returns 80/00/00 for index 3 -> pal_select=3 after 1 strobe, Red/Green/Blue=80/00/00 after 2 strobes.
REQ-034 SHALL verify background: all layers 0, blank=1 -> output 00/00/40 after 2 strobes.
REQ-035 SHALL verify blanking: blank=0 with layer 0 index 4 -> output 00/00/00; pixel_en held at 0 for 5 cycles -> outputs unchanged.
REQ-036 SHALL verify the flash sequence: flash_req, then 24 frame_start pulses -> ON/OFF alternate every 4 frames, 3 ON phases; only layer-1 pixels show FF/FF/FF during ON; flash_busy=0 after frame 24.
REQ-037 SHALL verify flash restart: flash_req at frame 6 of a flash -> FSM returns to ON with fcnt=0 and bcnt=0, and the sequence lasts 24 further frames.
REQ-038 SHALL verify reset mid-flash: Reset_n=0 during an ON phase -> IDLE, all outputs 0 immediately without waiting for a Clk edge, and no flash after release.
